// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: opcode/funct constants, FSM states, flag bits
// shared by the multiply/divide unit files.
package mips_muldiv_pkg;

   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   localparam logic [5:0] F_MADD  = 6'b000000;
   localparam logic [5:0] F_MADDU = 6'b000001;
   localparam logic [5:0] F_MSUB  = 6'b000100;
   localparam logic [5:0] F_MSUBU = 6'b000101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } state_e;

   localparam int FLAG_DZ   = 0;
   localparam int FLAG_NEG  = 1;
   localparam int FLAG_ZERO = 2;

endpackage

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: EX-stage request/response bundle of the
// multiply/divide unit (master = pipeline, slave = unit).
interface mips_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic             flush_i;
   logic [31:0]      instruction_i;
   logic [WIDTH-1:0] rega_i;
   logic [WIDTH-1:0] regb_i;
   logic             busy_o;
   logic             done_o;
   logic             stall_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;
   logic [WIDTH-1:0] result_o;
   logic [2:0]       flags_o;

   modport master (
      output start_i, flush_i, instruction_i,
      output rega_i, regb_i,
      input  busy_o, done_o, stall_o,
      input  hi_o, lo_o, result_o, flags_o
   );

   modport slave (
      input  start_i, flush_i, instruction_i,
      input  rega_i, regb_i,
      output busy_o, done_o, stall_o,
      output hi_o, lo_o, result_o, flags_o
   );
endinterface

// File: rtl/mips_muldiv_datapath.sv
// mips_muldiv_datapath: {acc, q} iteration registers; one
// shift-add (multiply) or restoring subtract (divide) per step.
module mips_muldiv_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] acc_q, q_q, b_q;
   logic [WIDTH:0]   sum, shl;
   logic [WIDTH-1:0] diff;
   logic             geq;

   // candidate results for both step kinds
   always_comb begin
      sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
      shl  = {acc_q, q_q[WIDTH-1]};
      geq  = shl >= {1'b0, b_q};
      diff = shl[WIDTH-1:0] - b_q;
   end

   // operand load and per-cycle iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         q_q   <= '0;
         b_q   <= '0;
      end else if (load_i) begin
         acc_q <= '0;
         q_q   <= a_i;
         b_q   <= b_i;
      end else if (step_i) begin
         if (div_i) begin
            acc_q <= geq ? diff : shl[WIDTH-1:0];
            q_q   <= {q_q[WIDTH-2:0], geq};
         end else begin
            acc_q <= sum[WIDTH:1];
            q_q   <= {sum[0], q_q[WIDTH-1:1]};
         end
      end
   end

   assign acc_o = acc_q;
   assign q_o   = q_q;

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MIPS mult/div with HI/LO.
// MIPS_MULDIV_MADD_EN adds SPECIAL2 madd/maddu/msub/msubu.
module mips_muldiv_unit
   import mips_muldiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input logic        clk,
   input logic        rst_n,
   mips_muldiv_if.slave bus
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q, dz_q, dz_pend_q;
   logic             div_q, macc_q, sub_q;
   logic             neg_p_q, neg_r_q;

   logic [5:0] opc, fn;
   logic d_mul, d_div, d_sgn, d_macc, d_sub;
   logic d_mfhi, d_mflo, d_mthi, d_mtlo, d_any;
   logic busy, accept, div0, rd;
   logic a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag, dp_acc, dp_q;
   logic [WIDTH-1:0] quot_s, rem_s, result;
   logic [2*WIDTH-1:0] prod_s, hilo_n;
   logic unused_instr;

   assign opc = bus.instruction_i[31:26];
   assign fn  = bus.instruction_i[5:0];
   assign unused_instr = ^bus.instruction_i[25:6];

   // instruction decode
   always_comb begin
      d_mul  = 1'b0;
      d_div  = 1'b0;
      d_sgn  = 1'b0;
      d_macc = 1'b0;
      d_sub  = 1'b0;
      d_mfhi = 1'b0;
      d_mflo = 1'b0;
      d_mthi = 1'b0;
      d_mtlo = 1'b0;
      if (opc == OP_SPECIAL) begin
         case (fn)
            F_MULT:  begin d_mul = 1'b1; d_sgn = 1'b1; end
            F_MULTU: d_mul = 1'b1;
            F_DIV:   begin d_div = 1'b1; d_sgn = 1'b1; end
            F_DIVU:  d_div = 1'b1;
            F_MFHI:  d_mfhi = 1'b1;
            F_MFLO:  d_mflo = 1'b1;
            F_MTHI:  d_mthi = 1'b1;
            F_MTLO:  d_mtlo = 1'b1;
            default: ;
         endcase
      end
`ifdef MIPS_MULDIV_MADD_EN
      if (opc == OP_SPECIAL2) begin
         case (fn)
            F_MADD:  begin d_mul = 1'b1; d_macc = 1'b1; d_sgn = 1'b1; end
            F_MADDU: begin d_mul = 1'b1; d_macc = 1'b1; end
            F_MSUB:  begin d_mul = 1'b1; d_macc = 1'b1; d_sub = 1'b1; d_sgn = 1'b1; end
            F_MSUBU: begin d_mul = 1'b1; d_macc = 1'b1; d_sub = 1'b1; end
            default: ;
         endcase
      end
`endif
      d_any = d_mul | d_div | d_mfhi | d_mflo | d_mthi | d_mtlo;
   end

   assign busy   = state_q != IDLE;
   assign accept = bus.start_i & ~busy & ~bus.flush_i;
   assign div0   = d_div & (bus.regb_i == '0);
   assign a_neg  = d_sgn & bus.rega_i[WIDTH-1];
   assign b_neg  = d_sgn & bus.regb_i[WIDTH-1];
   assign a_mag  = a_neg ? -bus.rega_i : bus.rega_i;
   assign b_mag  = b_neg ? -bus.regb_i : bus.regb_i;

   mips_muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept & (d_mul | d_div) & ~div0),
      .step_i ((state_q == MUL) | (state_q == DIV)),
      .div_i  (state_q == DIV),
      .a_i    (a_mag),
      .b_i    (b_mag),
      .acc_o  (dp_acc),
      .q_o    (dp_q)
   );

   // sign fix-up and accumulate applied in FIN
   always_comb begin
      prod_s = neg_p_q ? -{dp_acc, dp_q} : {dp_acc, dp_q};
      quot_s = neg_p_q ? -dp_q : dp_q;
      rem_s  = neg_r_q ? -dp_acc : dp_acc;
      hilo_n = prod_s;
      if (macc_q)
         hilo_n = sub_q ? {hi_q, lo_q} - prod_s
                        : {hi_q, lo_q} + prod_s;
   end

   // control FSM, counter, HI/LO and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         dz_pend_q <= 1'b0;
         div_q     <= 1'b0;
         macc_q    <= 1'b0;
         sub_q     <= 1'b0;
         neg_p_q   <= 1'b0;
         neg_r_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush_i) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: if (accept) begin
                  if (d_mthi) hi_q <= bus.rega_i;
                  if (d_mtlo) lo_q <= bus.rega_i;
                  if (d_mul | d_div) begin
                     cnt_q     <= CNT_W'(WIDTH);
                     div_q     <= d_div;
                     macc_q    <= d_macc;
                     sub_q     <= d_sub;
                     neg_p_q   <= a_neg ^ b_neg;
                     neg_r_q   <= a_neg;
                     dz_pend_q <= div0;
                     state_q   <= div0 ? FIN : (d_div ? DIV : MUL);
                  end
               end
               MUL, DIV: begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_q <= FIN;
               end
               FIN: begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                  dz_q    <= dz_pend_q;
                  if (!dz_pend_q) begin
                     if (div_q) begin
                        hi_q <= rem_s;
                        lo_q <= quot_s;
                     end else begin
                        {hi_q, lo_q} <= hilo_n;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rd     = bus.start_i & ~busy & (d_mfhi | d_mflo);
   assign result = !rd ? '0 : (d_mfhi ? hi_q : lo_q);

   assign bus.busy_o   = busy;
   assign bus.done_o   = done_q;
   assign bus.stall_o  = bus.start_i & busy & d_any;
   assign bus.hi_o     = hi_q;
   assign bus.lo_o     = lo_q;
   assign bus.result_o = result;
   assign bus.flags_o[FLAG_ZERO] = rd & (result == '0);
   assign bus.flags_o[FLAG_NEG]  = result[WIDTH-1];
   assign bus.flags_o[FLAG_DZ]   = dz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: random + directed checks of the mult/div
// unit against an arithmetic HI/LO reference model.
module tb_mips_muldiv_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic        m_dz = 1'b0;

   mips_muldiv_if #(.WIDTH(32)) bus ();

   mips_muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic decoded(input logic [31:0] ins);
      logic [5:0] o, f;
      o = ins[31:26];
      f = ins[5:0];
      if (o == 6'h00)
         return f inside {6'h18, 6'h19, 6'h1a, 6'h1b,
                          6'h10, 6'h11, 6'h12, 6'h13};
`ifdef MIPS_MULDIV_MADD_EN
      if (o == 6'h1c) return f inside {6'h00, 6'h01, 6'h04, 6'h05};
`endif
      return 1'b0;
   endfunction

   task automatic model_op(input logic [5:0] opc, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      longint sp;
      longint unsigned ua, ub;
      logic [63:0] p, acc;
      sa = a; sb = b; ua = a; ub = b;
      if (opc == 6'h1c) begin
         sp  = longint'(sa) * longint'(sb);
         p   = fn[0] ? ua * ub : sp;
         acc = {m_hi, m_lo};
         acc = fn[2] ? acc - p : acc + p;
         {m_hi, m_lo} = acc;
         m_dz = 1'b0;
         return;
      end
      case (fn)
         6'h18: begin
            sp = longint'(sa) * longint'(sb);
            p = sp;
            {m_hi, m_lo} = p;
            m_dz = 1'b0;
         end
         6'h19: begin
            p = ua * ub;
            {m_hi, m_lo} = p;
            m_dz = 1'b0;
         end
         6'h1a: begin
            m_dz = (b == 0);
            if (b == 0) ;
            else if (a == 32'h8000_0000 && sb == -1) begin
               m_lo = a; m_hi = 0;
            end else begin
               m_lo = sa / sb; m_hi = sa % sb;
            end
         end
         default: begin
            m_dz = (b == 0);
            if (b != 0) begin
               m_lo = a / b; m_hi = a % b;
            end
         end
      endcase
   endtask

   task automatic do_op(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      int n, nb, lat;
      logic seen;
      lat = (opc == 6'h00 && (fn == 6'h1a || fn == 6'h1b) && b == 0)
            ? 1 : 33;
      bus.instruction_i = {opc, 20'h0, fn};
      bus.rega_i = a;
      bus.regb_i = b;
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      model_op(opc, fn, a, b);
      n = 0; nb = 0; seen = 1'b0;
      while (!seen && n < 100) begin
         if (bus.busy_o) nb++;
         @(posedge clk); #1;
         n++;
         seen = bus.done_o;
      end
      check("latency", n, lat);
      check("busy_cycles", nb, lat);
      check("busy_at_done", bus.busy_o, 0);
      check("hi", bus.hi_o, m_hi);
      check("lo", bus.lo_o, m_lo);
      check("dz_flag", bus.flags_o[0], m_dz);
      @(posedge clk); #1;
      check("done_pulse", bus.done_o, 0);
   endtask

   task automatic mt(input logic hi_sel, input logic [31:0] v);
      bus.instruction_i = {26'h0, hi_sel ? 6'h11 : 6'h13};
      bus.rega_i = v;
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      if (hi_sel) m_hi = v; else m_lo = v;
      check("mt_no_done", bus.done_o, 0);
      check("mt_hi", bus.hi_o, m_hi);
      check("mt_lo", bus.lo_o, m_lo);
   endtask

   task automatic mf(input logic hi_sel);
      logic [31:0] e;
      e = hi_sel ? m_hi : m_lo;
      bus.instruction_i = {26'h0, hi_sel ? 6'h10 : 6'h12};
      bus.start_i = 1'b1;
      #1;
      check(hi_sel ? "mfhi" : "mflo", bus.result_o, e);
      check("flag_zero", bus.flags_o[2], e == 0);
      check("flag_neg", bus.flags_o[1], e[31]);
      @(posedge clk); #1;
      bus.start_i = 1'b0;
   endtask

   initial begin
      int n, nd;
      logic [31:0] ins, a, b;
      logic [5:0] fn;
      logic seen;
      bus.start_i = 0; bus.flush_i = 0;
      bus.instruction_i = 0; bus.rega_i = 0; bus.regb_i = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_hilo", {bus.hi_o, bus.lo_o}, 0);
      check("rst_res", {bus.result_o, bus.flags_o, bus.stall_o}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(6'h00, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_hi_const", bus.hi_o, 32'hFFFF_FFFE);
      check("multu_lo_const", bus.lo_o, 32'h0000_0001);
      do_op(6'h00, 6'h18, -32'd3, 32'd5);
      check("mult_lo_const", bus.lo_o, 32'hFFFF_FFF1);
      do_op(6'h00, 6'h1a, -32'd7, 32'd2);
      check("div_lo_const", bus.lo_o, 32'hFFFF_FFFD);
      check("div_hi_const", bus.hi_o, 32'hFFFF_FFFF);
      do_op(6'h00, 6'h1b, 32'd7, 32'd2);
      do_op(6'h00, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
      check("minm1_lo_const", bus.lo_o, 32'h8000_0000);
      do_op(6'h00, 6'h1a, 32'd5, 32'd0);
      check("div0_lo_kept", bus.lo_o, 32'h8000_0000);

      mt(1'b1, 32'h1234_5678);
      mf(1'b1);
      mt(1'b0, 32'h0);
      mf(1'b0);
      mt(1'b0, 32'h8000_0001);
      mf(1'b0);

      // stall during a busy mult; other instructions not accepted
      bus.instruction_i = {6'h00, 20'h0, 6'h18};
      bus.rega_i = 32'd6; bus.regb_i = 32'd7; bus.start_i = 1'b1;
      @(posedge clk); #1;
      model_op(6'h00, 6'h18, 32'd6, 32'd7);
      bus.rega_i = 32'd100; bus.regb_i = 32'd200;
      n = 0; seen = 1'b0;
      while (!seen && n < 100) begin
         if (n < 10) ins = {6'h00, 20'h0, 6'h12};
         else if (n < 20) ins = {6'h00, 20'h0, 6'h18};
         else if (n == 20) ins = {6'h00, 20'h0, 6'h20};
         else if (n == 21) ins = {6'h1c, 20'h0, 6'h00};
         else ins = {6'h00, 20'h0, 6'h12};
         bus.instruction_i = ins;
         #1;
         check("stall", bus.stall_o, decoded(ins));
         if (ins == {6'h00, 20'h0, 6'h12})
            check("mf_busy_res", bus.result_o, 0);
         @(posedge clk); #1;
         n++;
         seen = bus.done_o;
      end
      check("stall_lat", n, 33);
      check("mflo_after", bus.result_o, 32'd42);
      bus.start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no_queue_busy", bus.busy_o, 0);
      check("no_queue_lo", bus.lo_o, m_lo);

      // flush in cycle 10 of a mult
      bus.instruction_i = {6'h00, 20'h0, 6'h18};
      bus.rega_i = 32'h1234; bus.regb_i = 32'h5678; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      check("flush_busy", bus.busy_o, 0);
      nd = 0;
      repeat (40) begin
         if (bus.done_o) nd++;
         @(posedge clk); #1;
      end
      check("flush_no_done", nd, 0);
      check("flush_hi", bus.hi_o, m_hi);
      check("flush_lo", bus.lo_o, m_lo);
      bus.instruction_i = {26'h0, 6'h11};
      bus.rega_i = 32'hDEAD_BEEF;
      bus.start_i = 1'b1; bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      check("flush_wins", bus.hi_o, m_hi);

      for (int i = 0; i < 40; i++) begin
         fn = 6'h18 + 6'($urandom_range(0, 3));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 9))
            0: b = 0;
            1: b = $urandom_range(1, 15);
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: b = 32'hFFFF_FFFF - $urandom_range(0, 14);
            4: a = $urandom_range(0, 255);
            default: ;
         endcase
         do_op(6'h00, fn, a, b);
      end

`ifdef MIPS_MULDIV_MADD_EN
      do_op(6'h00, 6'h18, 32'd2, 32'd3);
      do_op(6'h1c, 6'h00, 32'd4, 32'd5);
      check("madd_lo_const", bus.lo_o, 32'd26);
      check("madd_hi_const", bus.hi_o, 32'd0);
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 3))
            0: fn = 6'h00;
            1: fn = 6'h01;
            2: fn = 6'h04;
            default: fn = 6'h05;
         endcase
         do_op(6'h1c, fn, $urandom, $urandom);
      end
`endif

      // asynchronous reset in the middle of a divide
      bus.instruction_i = {6'h00, 20'h0, 6'h1b};
      bus.rega_i = 32'hFFFF_0000; bus.regb_i = 32'd3; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", bus.busy_o, 0);
      check("arst_done", bus.done_o, 0);
      check("arst_hilo", {bus.hi_o, bus.lo_o}, 0);
      check("arst_res", {bus.result_o, bus.flags_o, bus.stall_o}, 0);
      m_hi = 0; m_lo = 0; m_dz = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(6'h00, 6'h1b, 32'd100, 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
